// File: rtl/fir_pio_ctrl.sv
// fir_pio_ctrl: command sequencer for the lab FIR accelerator.
// Software writes commands on out0/out1 and signals each one by flipping out1[0].
// The block owns the coefficient store and the sample ring buffer. It steps one
// shared 16x16 MAC through one tap per cycle. The 40-bit result and the
// handshake status are returned on in_h/in_l.
// Optional feature macro: FIR_PIO_SAT_EN. When defined, the result is clamped
// to signed 32 bits at DONE.
module fir_pio_ctrl #(
    parameter int TAPS = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] out0_i,
    input  logic [31:0] out1_i,
    output logic [31:0] in_l_o,
    output logic [31:0] in_h_o,
    output logic [9:0]  led_o
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);
    localparam logic [6:0]    TAPS_W   = 7'(TAPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MAC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH,
        OP_LOADC,
        OP_CLEAR,
        OP_RSVD
    } op_t;

    state_t state_reg;
    op_t    op_reg;

    logic                 tog_reg;
    logic                 primed_reg;
    logic signed [15:0]   data_reg;
    logic [IW-1:0]        wp_reg;
    logic [IW-1:0]        k_reg;
    logic [IW-1:0]        rd_reg;
    logic signed [39:0]   acc_reg;
    logic [31:0]          res_lo_reg;
    logic [7:0]           res_hi_reg;
    logic                 ack_reg;
    logic                 busy_reg;
    logic                 ovr_reg;

    logic signed [15:0]   coef_arr [TAPS];
    logic signed [15:0]   samp_arr [TAPS];

    logic                 cmd_edge;
    logic                 cmd_take;
    op_t                  cmd_op;
    logic [5:0]           cmd_idx;
    logic                 coef_we;
    logic                 clear_en;
    logic                 samp_we;

    logic signed [15:0]   coef_sel;
    logic signed [15:0]   samp_sel;
    logic signed [31:0]   prod;
    logic signed [39:0]   acc_next;
    logic [31:0]          res_lo_next;
    logic [7:0]           res_hi_next;

    // Bits of the PIO words that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{out0_i[31:16], out1_i[31:14], out1_i[7:3]};

    // Command decode. The first cycle after reset only primes tog_reg, so a
    // toggle level left over from before reset never fires a command.
    assign cmd_edge = primed_reg && (out1_i[0] != tog_reg);
    assign cmd_take = cmd_edge && (state_reg == ST_IDLE);
    assign cmd_op   = op_t'(out1_i[2:1]);
    assign cmd_idx  = out1_i[13:8];
    assign coef_we  = cmd_take && (cmd_op == OP_LOADC) && ({1'b0, cmd_idx} < TAPS_W);
    assign clear_en = cmd_take && (cmd_op == OP_CLEAR);
    assign samp_we  = (state_reg == ST_SHIFT);

    // Per-tap storage. Everything clears on reset, so these are flops, not RAM.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
        logic signed [15:0] coef_reg;
        logic signed [15:0] samp_reg;

        // Coefficient slot gi is written only by an in-range LOADC that addresses it.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                coef_reg <= '0;
            end else if (coef_we && (cmd_idx == 6'(gi))) begin
                coef_reg <= out0_i[15:0];
            end
        end

        // Sample slot gi is cleared by CLEAR, or takes the latched PUSH data when wp points here.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                samp_reg <= '0;
            end else if (clear_en) begin
                samp_reg <= '0;
            end else if (samp_we && (wp_reg == IW'(gi))) begin
                samp_reg <= data_reg;
            end
        end

        assign coef_arr[gi] = coef_reg;
        assign samp_arr[gi] = samp_reg;
    end

    // One MAC step: coef[k] times the sample k positions older than the newest one.
    assign coef_sel = coef_arr[k_reg];
    assign samp_sel = samp_arr[rd_reg];
    assign prod     = 32'(coef_sel) * 32'(samp_sel);
    assign acc_next = acc_reg + 40'(prod);

`ifdef FIR_PIO_SAT_EN
    localparam logic signed [39:0] SAT_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [39:0] SAT_MIN = 40'shFF_8000_0000;

    // Clamp to signed 32 bits. The high byte is then only the sign extension.
    always_comb begin
        res_lo_next = acc_reg[31:0];
        res_hi_next = {8{acc_reg[31]}};
        if (acc_reg > SAT_MAX) begin
            res_lo_next = 32'h7FFF_FFFF;
            res_hi_next = 8'h00;
        end else if (acc_reg < SAT_MIN) begin
            res_lo_next = 32'h8000_0000;
            res_hi_next = 8'hFF;
        end
    end
`else
    // Present the raw 40-bit accumulator split across the two result words.
    always_comb begin
        res_lo_next = acc_reg[31:0];
        res_hi_next = acc_reg[39:32];
    end
`endif

    // Sequencer FSM with the handshake, status and result registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_PUSH;
            tog_reg    <= 1'b0;
            primed_reg <= 1'b0;
            data_reg   <= '0;
            wp_reg     <= '0;
            k_reg      <= '0;
            rd_reg     <= '0;
            acc_reg    <= '0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            ack_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            primed_reg <= 1'b1;
            tog_reg    <= out1_i[0];

            // A command that arrives while busy is dropped, but it is remembered here.
            if (cmd_edge && (state_reg != ST_IDLE)) begin
                ovr_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_take) begin
                        busy_reg <= 1'b1;
                        op_reg   <= cmd_op;
                        data_reg <= out0_i[15:0];
                        if (cmd_op == OP_PUSH) begin
                            state_reg <= ST_SHIFT;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                        if (cmd_op == OP_CLEAR) begin
                            wp_reg  <= '0;
                            ovr_reg <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    // The sample lands at wp during this edge, and wp is the newest position.
                    acc_reg   <= '0;
                    k_reg     <= '0;
                    rd_reg    <= wp_reg;
                    state_reg <= ST_MAC;
                end
                ST_MAC: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + 1'b1;
                    rd_reg  <= (rd_reg == '0) ? LAST_IDX : rd_reg - 1'b1;
                    if (k_reg == LAST_IDX) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack_reg   <= ~ack_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                    if (op_reg == OP_PUSH) begin
                        res_lo_reg <= res_lo_next;
                        res_hi_reg <= res_hi_next;
                        wp_reg     <= (wp_reg == LAST_IDX) ? '0 : wp_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_l_o = res_lo_reg;
    assign in_h_o = {ack_reg, busy_reg, ovr_reg, 21'b0, res_hi_reg};
    assign led_o  = {res_hi_reg, ovr_reg, busy_reg};

endmodule

// File: doc/fir_pio_ctrl.md
# fir_pio_ctrl

Sequencing controller for the lab FIR accelerator: sits between the Nios II parallel-I/O ports (`out0`/`out1` driven by software, `in_h`/`in_l` read by software) and a single shared 16×16 multiply-accumulate datapath. It decodes toggle-handshaked commands from software, owns the coefficient store and the sample ring buffer, and steps the MAC through one tap per cycle. The 40-bit result and handshake status are returned on the `in_h`/`in_l` words.

## Interface
- `TAPS`, 16, number of filter taps; legal range 2..64, not required to be a power of two.
- `clk_clk`  input  1  system clock; all logic on rising edge.
- `reset_reset_n`  input  1  reset, asynchronous assert, active-low.
- `out0_i`  input  32  command data; `[15:0]` is a signed sample or coefficient.
- `out1_i`  input  32  command control:
  - `[0]` command toggle.
  - `[2:1]` opcode: 0 = PUSH, 1 = LOADC, 2 = CLEAR, 3 = reserved (no-op, still acknowledged).
  - `[13:8]` coefficient index.
- `in_l_o`  output  32  result `[31:0]`.
- `in_h_o`  output  32  status and result high word:
  - `[31]` ack toggle.
  - `[30]` busy.
  - `[29]` overrun sticky.
  - `[28:8]` zero.
  - `[7:0]` result `[39:32]`.
- `led_o`  output  10  `[0]` busy, `[1]` overrun, `[9:2]` = `in_h_o[7:0]`.

## Operation
- Command detection: a command is taken when `out1_i[0]` differs from registered `tog_q` while the FSM is in IDLE. `tog_q` updates every cycle.
- First cycle after reset release: `tog_q` loads `out1_i[0]` with no command detected, so a stale toggle level does not fire.
- FSM states: IDLE, SHIFT, MAC, DONE.
  - IDLE + PUSH: go to SHIFT; busy = 1.
  - IDLE + LOADC: write `coef[idx]` if `idx < TAPS`, otherwise ignore the write; go to DONE.
  - IDLE + CLEAR: zero all samples, the write pointer and the overrun flag in the same edge; go to DONE.
  - SHIFT: write sample at `wp`; `wp` becomes newest position `p`; clear the accumulator; `k = 0`; go to MAC.
  - MAC: `acc += coef[k] * x[(p - k) mod TAPS]`, one tap per cycle. Index wraps from 0 to `TAPS-1`. At `k = TAPS-1`, go to DONE.
  - DONE: register the result to the outputs, invert ack, busy = 0, go to IDLE. `wp` advances to `(p + 1) mod TAPS` only after a PUSH.
- Result: `y = Σ coef[k]·x[n−k]` for k = 0..TAPS-1.
  - Products are signed 32-bit.
  - The accumulator is signed 40-bit and cannot overflow for `TAPS ≤ 64`.
- Overrun: a toggle change seen while not in IDLE sets the overrun flag and the command is dropped (no ack for it). The flag clears only on CLEAR or reset.
- Results hold until the next DONE that follows a PUSH. LOADC and CLEAR do not modify the result fields.
- Reset (at any point, including mid-MAC): abandons the operation.
  - FSM = IDLE; coefficients, samples, `wp`, `acc` = 0.
  - All outputs = 0: `in_h_o = 0`, `in_l_o = 0`, `led_o = 0`.

## Timing
- Out1 toggle first sampled at edge T (FSM in IDLE):
  - PUSH: busy rises at T; ack inverts at T+TAPS+2; busy falls at the same edge.
  - LOADC, CLEAR, reserved: busy rises at T; ack and busy fall at T+1.
- Result and status outputs are registered; there is no combinational path from inputs to outputs.
- Minimum command spacing with no overrun is one cycle after the ack edge. A toggle change exactly at the ack edge is detected as overrun, because the FSM is still in DONE.

## Configuration
- `FIR_PIO_SAT_EN` defined:
  - At DONE the result is saturated to signed 32-bit: `in_l_o` = clamp(acc, −2^31, 2^31−1).
  - `in_h_o[7:0]` = sign-extension byte of the clamped value (0x00 or 0xFF).
- Undefined: raw 40-bit accumulator presented as described in Interface.

## Test plan
- TAPS=4; LOADC coefs 1, 2, 3, 4 at idx 0..3; PUSH 100, 200, 300 -> `in_l_o` = 100, 400, 1000 in turn; `in_h_o[7:0]` = 0; each ack arrives exactly 6 cycles after its toggle.
- TAPS=4; all coefs 32767; PUSH 32767 ×4 -> without macro `in_l_o` = 0xFFFC0004, `in_h_o[7:0]` = 0x00; with `FIR_PIO_SAT_EN` `in_l_o` = 0x7FFFFFFF.
- TAPS=4; PUSH 6 samples 1..6 with coefs 1, 0, 0, 1 -> after the 6th sample `in_l_o` = 6+3 = 9, confirming ring wrap-around.
- Toggle PUSH, then toggle again 2 cycles later -> second command dropped; `in_h_o[29]` = 1; one ack only; CLEAR -> `in_h_o[29]` = 0 and the next PUSH of 5 with coef0 = 1 gives 5.
- Assert reset at MAC cycle 2 while `out1_i[0]` = 1, then release -> all outputs 0; no command fires on release; the next toggle to 0 is accepted.
- LOADC idx 63 with TAPS=4 -> ack at T+1; the following PUSH gives a result unchanged by the ignored write.
